// File: rtl/cipher_pkg.sv
// Shared cipher datapath types: iterative-engine FSM states and the 16-bit nibble-mixing layer.
package cipher_pkg;

  localparam int COL_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mix_state_e;

  // The nibble order is n0 = [3:0] through n3 = [15:12].
  function automatic logic [COL_W-1:0] mix_fwd(input logic [COL_W-1:0] n);
    logic [3:0] o0, o1, o2, o3;
    o0 = n[15:12] ^ n[11:8];
    o1 = n[3:0];
    o2 = n[3:0] ^ n[7:4];
    o3 = n[11:8];
    return {o3, o2, o1, o0};
  endfunction

  function automatic logic [COL_W-1:0] mix_inv(input logic [COL_W-1:0] o);
    logic [3:0] n0, n1, n2, n3;
    n0 = o[7:4];
    n1 = o[11:8] ^ o[7:4];
    n2 = o[15:12];
    n3 = o[3:0] ^ o[15:12];
    return {n3, n2, n1, n0};
  endfunction

endpackage

// File: rtl/mix_col.sv
// Combinational forward/inverse nibble-mixing transform of one 16-bit column.
// Zero latency and no flow control: the enclosing engine registers the result.
module mix_col
  import cipher_pkg::*;
(
  input  logic [COL_W-1:0] i_col,
  input  logic             i_inv,
  output logic [COL_W-1:0] o_col
);

  assign o_col = i_inv ? mix_inv(i_col) : mix_fwd(i_col);

endmodule

// File: rtl/mix_layer_iter.sv
// Iterative mixing engine: NCOL columns, one layer pass per clock, one word in flight.
// Result valid P edges after accept (P=0: on the accept edge); output holds under backpressure.
module mix_layer_iter
  import cipher_pkg::*;
#(
  parameter int NCOL   = 4,
  parameter int PASS_W = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [NCOL*COL_W-1:0] i_in_data,
  input  logic                  i_in_inv,
  input  logic [PASS_W-1:0]     i_in_passes,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [NCOL*COL_W-1:0] o_out_data
);

  mix_state_e              r_fsm;
  mix_state_e              w_fsm_nxt;
  logic [NCOL*COL_W-1:0]   r_data;
  logic [NCOL*COL_W-1:0]   w_mixed;
  logic                    r_mode;
  logic [PASS_W-1:0]       r_cnt;
  logic                    w_accept;

  for (genvar c = 0; c < NCOL; c++) begin : g_col
    mix_col u_mix_col (
      .i_col (r_data[c*COL_W +: COL_W]),
      .i_inv (r_mode),
      .o_col (w_mixed[c*COL_W +: COL_W])
    );
  end

  // Handshake outputs depend only on the registered state.
  assign o_in_ready  = (r_fsm == ST_IDLE);
  assign o_out_valid = (r_fsm == ST_DONE);
  assign o_out_data  = r_data;
  assign w_accept    = i_in_valid && o_in_ready;

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      ST_IDLE: begin
        if (w_accept) begin
          w_fsm_nxt = (i_in_passes == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == PASS_W'(1)) begin
          w_fsm_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_out_ready) begin
          w_fsm_nxt = ST_IDLE;
        end
      end
      default: w_fsm_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fsm <= ST_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data <= '0;
      r_mode <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (r_fsm == ST_IDLE) begin
        if (w_accept) begin
          r_data <= i_in_data;
          r_mode <= i_in_inv;
          r_cnt  <= i_in_passes;
        end
      end else if (r_fsm == ST_RUN) begin
        r_data <= w_mixed;
        r_cnt  <= r_cnt - PASS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mix_layer_iter.sv
// Directed bench for mix_layer_iter (NCOL=4, PASS_W=3); expected values derived by hand from the nibble equations.
module tb_mix_layer_iter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [63:0] i_in_data;
  logic        i_in_inv;
  logic [2:0]  i_in_passes;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [63:0] o_out_data;

  int n_chk  = 0;
  int n_pass = 0;

  mix_layer_iter #(.NCOL(4), .PASS_W(3)) u_dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (i_in_data),
    .i_in_inv    (i_in_inv),
    .i_in_passes (i_in_passes),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_data  (o_out_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Offer one word, wait for the result, leave it un-acknowledged in DONE.
  task automatic start_word(input logic [63:0] d, input logic inv, input logic [2:0] p,
                            output int lat);
    @(negedge i_clk);
    i_in_valid  = 1'b1;
    i_in_data   = d;
    i_in_inv    = inv;
    i_in_passes = p;
    @(posedge i_clk);
    @(negedge i_clk);
    i_in_valid  = 1'b0;
    i_in_data   = ~d;
    i_in_inv    = ~inv;
    i_in_passes = ~p;
    lat = 0;
    while (!o_out_valid && lat < 20) begin
      @(negedge i_clk);
      lat++;
    end
  endtask

  task automatic release_word();
    i_out_ready = 1'b1;
    @(negedge i_clk);
    i_out_ready = 1'b0;
  endtask

  task automatic run_word(input string tag, input logic [63:0] d, input logic inv,
                          input logic [2:0] p, output logic [63:0] res);
    int lat;
    start_word(d, inv, p, lat);
    check({tag, "_lat"}, 64'(lat), 64'(p));
    check({tag, "_inrdy"}, 64'(o_in_ready), 64'd0);
    res = o_out_data;
    release_word();
    check({tag, "_idle"}, 64'(o_in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] res, orig, mid, held;
    int lat;
    i_rst       = 1'b1;
    i_in_valid  = 1'b0;
    i_in_data   = '0;
    i_in_inv    = 1'b0;
    i_in_passes = '0;
    i_out_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    check("rst_inrdy", 64'(o_in_ready), 64'd1);
    check("rst_outvld", 64'(o_out_valid), 64'd0);
    check("rst_data", o_out_data, 64'd0);
    i_rst = 1'b0;

    run_word("fwd1", 64'h1234, 1'b0, 3'd1, res);
    check("fwd1_data", res, 64'h2743);
    run_word("inv1", 64'h2743, 1'b1, 3'd1, res);
    check("inv1_data", res, 64'h1234);
    run_word("fwd2", 64'h1234, 1'b0, 3'd2, res);
    check("fwd2_data", res, 64'h7735);
    // Forward layer has period 6 on 0x1234, so 7 passes land on the 1-pass value.
    run_word("fwd7", 64'h1234, 1'b0, 3'd7, res);
    check("fwd7_data", res, 64'h2743);
    run_word("fwd6", 64'h1234, 1'b0, 3'd6, res);
    check("fwd6_data", res, 64'h1234);

    run_word("c4f", 64'h2743_FFFF_0000_1234, 1'b0, 3'd1, res);
    check("c4f_col0", 64'(res[15:0]),  64'h2743);
    check("c4f_col1", 64'(res[31:16]), 64'h0000);
    check("c4f_col2", 64'(res[47:32]), 64'hF0F0);
    check("c4f_col3", 64'(res[63:48]), 64'h7735);
    run_word("c4i", 64'h2743_FFFF_0000_1234, 1'b1, 3'd1, res);
    check("c4i_col0", 64'(res[15:0]),  64'h5113);
    check("c4i_col1", 64'(res[31:16]), 64'h0000);
    check("c4i_col2", 64'(res[47:32]), 64'h0F0F);
    check("c4i_col3", 64'(res[63:48]), 64'h1234);

    run_word("p0", 64'hDEAD_BEEF_0123_4567, 1'b0, 3'd0, res);
    check("p0_data", res, 64'hDEAD_BEEF_0123_4567);

    start_word(64'h1234, 1'b0, 3'd2, lat);
    check("bp_lat", 64'(lat), 64'd2);
    held = o_out_data;
    check("bp_first", held, 64'h7735);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      check($sformatf("bp_hold%0d", i), o_out_data, 64'h7735);
      check($sformatf("bp_vld%0d", i), 64'(o_out_valid), 64'd1);
      check($sformatf("bp_inrdy%0d", i), 64'(o_in_ready), 64'd0);
    end
    release_word();

    for (int i = 0; i < 3; i++) begin
      logic [2:0] k;
      k    = 3'($urandom_range(1, 7));
      orig = {$urandom, $urandom};
      run_word($sformatf("rt%0d_f", i), orig, 1'b0, k, mid);
      run_word($sformatf("rt%0d_i", i), mid, 1'b1, k, res);
      check($sformatf("rt%0d_data", i), res, orig);
    end

    @(negedge i_clk);
    i_in_valid  = 1'b1;
    i_in_data   = 64'hFFFF_FFFF_FFFF_FFFF;
    i_in_inv    = 1'b0;
    i_in_passes = 3'd7;
    @(negedge i_clk);
    i_in_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    check("mrst_inrdy", 64'(o_in_ready), 64'd1);
    check("mrst_outvld", 64'(o_out_valid), 64'd0);
    check("mrst_data", o_out_data, 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    run_word("post", 64'h1234, 1'b0, 3'd1, res);
    check("post_data", res, 64'h2743);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
